// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: distributes slot beats to per-channel holding registers.
// Optional TDM_DEMUX_SLIP_CNT_EN adds a saturating 8-bit slip counter on port slip_count.
module tdm_demux #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      sync,
  output logic [CHANNELS*WIDTH-1:0] ch_data,
  output logic [CHANNELS-1:0]       ch_valid,
  output logic                      frame_done,
  output logic                      locked,
  output logic                      slip,
  output logic [SEL_W-1:0]          slot
`ifdef TDM_DEMUX_SLIP_CNT_EN
  ,
  output logic [7:0]                slip_count
`endif
);

  localparam int unsigned DATA_W = CHANNELS * WIDTH;
  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(CHANNELS - 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state, state_next;
  logic [SEL_W-1:0]    slot_next;
  logic [DATA_W-1:0]   data_next;
  logic [CHANNELS-1:0] valid_next;
  logic                frame_done_next;
  logic                slip_next;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_next;
  end

  // Next-state and next-output decode for one accepted beat
  always_comb begin
    state_next      = state;
    slot_next       = slot;
    data_next       = ch_data;
    valid_next      = '0;
    frame_done_next = 1'b0;
    slip_next       = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (sync) begin
            data_next[0 +: WIDTH] = din;
            valid_next[0]         = 1'b1;
            slot_next             = SEL_W'(1);
            state_next            = LOCKED;
          end
        end
        LOCKED: begin
          if (sync) begin
            // Early sync abandons the partial frame and realigns on this beat
            slip_next             = (slot != '0);
            data_next[0 +: WIDTH] = din;
            valid_next[0]         = 1'b1;
            slot_next             = SEL_W'(1);
          end else if (slot == '0) begin
            slip_next  = 1'b1;
            slot_next  = '0;
            state_next = HUNT;
          end else begin
            data_next[slot*WIDTH +: WIDTH] = din;
            valid_next[slot]               = 1'b1;
            slot_next                      = slot + SEL_W'(1);
            frame_done_next                = (slot == LAST_SLOT);
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot       <= '0;
      ch_data    <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      slip       <= 1'b0;
    end else begin
      slot       <= slot_next;
      ch_data    <= data_next;
      ch_valid   <= valid_next;
      frame_done <= frame_done_next;
      locked     <= (state_next == LOCKED);
      slip       <= slip_next;
    end
  end

`ifdef TDM_DEMUX_SLIP_CNT_EN
  // Saturating slip counter, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               slip_count <= 8'd0;
    else if (slip_next && slip_count != 8'hFF) slip_count <= slip_count + 8'd1;
  end
`endif

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive side of the 4:1 channel multiplexer: takes one time-division-multiplexed stream (one slot per channel, slot 0 flagged by sync) and distributes each beat to its per-channel holding register.
- Frame alignment is tracked by a slot counter and a HUNT/LOCKED state machine.
- Misalignment is flagged and recovered without software help.
- Sits between the muxed link and per-channel consumers.

Parameters:
- CHANNELS, 4, number of TDM slots per frame; power of two, ≥2.
- WIDTH, 1, bits per slot beat.
- SEL_W, 2, slot counter width; must equal log2(CHANNELS).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  WIDTH  slot data beat.
- din_valid  in  1  din is a beat this cycle.
- sync  in  1  qualified by din_valid; marks this beat as slot 0.
- ch_data  out  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- ch_valid  out  CHANNELS  one-cycle pulse; channel k updated.
- frame_done  out  1  one-cycle pulse; slot CHANNELS-1 of an aligned frame written.
- locked  out  1  high in LOCKED state.
- slip  out  1  one-cycle pulse; alignment error detected.
- slot  out  SEL_W  slot index the next accepted beat will be written to.
- slip_count  out  8  present only with TDM_DEMUX_SLIP_CNT_EN.

Behaviour:
- Reset (async assert, sync-deassert by clk domain): state=HUNT, slot=0, ch_data=0, ch_valid=0, frame_done=0, locked=0, slip=0, slip_count=0. Reset mid-frame discards the partial frame; the next frame needs a fresh sync.
- Accepted beat: din_valid=1 in the cycle, sampled on the clk edge. sync with din_valid=0 is ignored.
- All outputs are registered. Latency is 1 cycle from the accepting edge: ch_data[k] updates, ch_valid[k] pulses for one cycle, and frame_done/slip pulse in that same cycle.
- ch_data holds its value until overwritten. At most one ch_valid bit is high per cycle.
- HUNT:
  - Beats without sync are discarded; no outputs change.
  - A beat with sync is written to ch 0, slot→1, state→LOCKED.
- LOCKED, beat at slot s:
  - sync=0 and s≠0: write ch s, slot→(s+1) mod CHANNELS.
  - s=CHANNELS-1: additionally pulse frame_done.
  - sync=1 and s=0: normal write of ch 0, slot→1.
  - sync=1 and s≠0 (early sync): pulse slip, write beat to ch 0, slot→1, stay LOCKED. The partial frame is abandoned; no frame_done.
  - sync=0 and s=0 (missing sync): pulse slip, discard beat (no ch_valid), slot→0, state→HUNT.
- slot wraps CHANNELS-1→0 with no overflow condition.
- din_valid gaps of any length are allowed mid-frame; state and slot hold.
- locked equals (state==LOCKED), registered.

Optional Feature:
- Macro: TDM_DEMUX_SLIP_CNT_EN.
- Defined: adds the slip_count port, an 8-bit counter incremented on every slip pulse. It saturates at 255 and clears only on reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then aligned frame: beats 1,0,1,1 (WIDTH=1) with sync on the first -> ch_valid pulses 0001,0010,0100,1000 on consecutive cycles; ch_data=4'b1101; frame_done one pulse with the last ch_valid; locked=1 after first beat.
- Pre-sync garbage: 3 beats without sync while in HUNT -> no ch_valid, ch_data stays 0, locked=0.
- Early sync: sync arrives at slot 2 -> slip=1 for one cycle, ch_valid=0001, slot=1 afterward, no frame_done, locked stays 1; slip_count=1 if enabled.
- Missing sync: 5th beat without sync after a full frame -> slip pulse, no ch_valid, locked=0. Next beat with sync relocks and writes ch 0.
- Gapped input: din_valid low for 4 cycles between slots 1 and 2 -> slot holds at 2; the frame completes normally with frame_done.
- Async reset mid-frame: rst_n low at slot 2 -> all outputs 0 immediately. After release, a sync-less beat is discarded.
